// File: rtl/sprite_cmd_unit.sv
// Per-sprite state store and command responder for the sprite instruction stream.
// A frame_tick launches a one-sprite-per-cycle movement sweep that stalls EX while it runs.
module sprite_cmd_unit #(
    parameter int         NUM_SPR = 256,
    parameter int         X_MAX   = 640,
    parameter int         Y_MAX   = 480,
    parameter logic [4:0] OP_ACT  = 5'h10,
    parameter logic [4:0] OP_LD   = 5'h11,
    parameter logic [4:0] OP_RD   = 5'h12,
    parameter logic [4:0] OP_MAP  = 5'h13,
    parameter logic [4:0] OP_CORD = 5'h14,
    parameter logic [4:0] OP_TM   = 5'h15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sprite_re,
    input  logic        sprite_we,
    input  logic [4:0]  sprite_op,
    input  logic [7:0]  sprite_addr,
    input  logic [3:0]  sprite_action,
    input  logic        sprite_use_imm,
    input  logic [9:0]  sprite_imm,
    input  logic [31:0] reg_data,
    input  logic        frame_tick,
    output logic        cmd_stall,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        sweep_busy,
    output logic        sweep_overrun
);

    // state | meaning
    // IDLE  | commands serviced; a tick or pending tick starts a sweep
    // SWEEP | sprite idx moved this cycle; commands stalled
    typedef enum logic {IDLE, SWEEP} state_t;

    localparam logic [7:0]  LAST_IDX = 8'(NUM_SPR - 1);
    localparam logic [10:0] XM       = 11'(X_MAX);
    localparam logic [10:0] YM       = 11'(Y_MAX);

    state_t     state, state_nxt;
    logic [7:0] idx;
    logic       pending;

    logic [9:0] spr_x    [NUM_SPR];
    logic [9:0] spr_y    [NUM_SPR];
    logic [3:0] spr_step [NUM_SPR];
    logic [3:0] spr_act  [NUM_SPR];
    logic [7:0] spr_img  [NUM_SPR];

    logic        accept, addr_ok, is_wr_op, is_rd_op, wr_en, rd_en;
    logic [9:0]  data, ld_lim, ld_val;
    logic [31:0] rd_word;
    logic [9:0]  cur_x, cur_y, mov_x, mov_y;
    logic [3:0]  cur_step, cur_act;
    logic [10:0] x_sum, y_sum;

    logic unused_reg_bits;
    assign unused_reg_bits = ^reg_data[31:10];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_tick || pending) state_nxt = SWEEP;
            SWEEP:   if (idx == LAST_IDX) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_stall  = (state == SWEEP);
    assign sweep_busy = (state == SWEEP);

    always_comb begin
        addr_ok  = {1'b0, sprite_addr} < 9'(NUM_SPR);
        is_wr_op = (sprite_op == OP_ACT) || (sprite_op == OP_LD) ||
                   (sprite_op == OP_MAP) || (sprite_op == OP_TM);
        is_rd_op = (sprite_op == OP_RD) || (sprite_op == OP_CORD);
        accept   = (sprite_re || sprite_we) && !cmd_stall;
        wr_en    = accept && sprite_we && !sprite_re && is_wr_op && addr_ok;
        rd_en    = accept && sprite_re && !sprite_we && is_rd_op;
        data     = sprite_use_imm ? sprite_imm : reg_data[9:0];
        ld_lim   = sprite_action[0] ? 10'(Y_MAX) : 10'(X_MAX);
        ld_val   = (data >= ld_lim) ? data - ld_lim : data;
        rd_word  = 32'd0;
        if (addr_ok) begin
            if (sprite_op == OP_RD)
                rd_word = {4'b0, spr_act[sprite_addr], spr_step[sprite_addr],
                           spr_img[sprite_addr], 2'b0, 10'b0};
            else
                rd_word = {6'b0, spr_y[sprite_addr], 6'b0, spr_x[sprite_addr]};
        end
    end

    // Movement for the sprite under the sweep pointer; opposing direction bits cancel.
    always_comb begin
        cur_x    = spr_x[idx];
        cur_y    = spr_y[idx];
        cur_step = spr_step[idx];
        cur_act  = spr_act[idx];
        x_sum    = {1'b0, cur_x} + 11'(cur_step);
        y_sum    = {1'b0, cur_y} + 11'(cur_step);
        mov_x    = cur_x;
        mov_y    = cur_y;
        if (cur_step != 4'd0) begin
            if (cur_act[3] && !cur_act[2])
                mov_x = (x_sum >= XM) ? 10'(x_sum - XM) : x_sum[9:0];
            else if (cur_act[2] && !cur_act[3])
                mov_x = (cur_x < 10'(cur_step)) ? 10'({1'b0, cur_x} + XM - 11'(cur_step))
                                                : cur_x - 10'(cur_step);
            if (cur_act[1] && !cur_act[0])
                mov_y = (y_sum >= YM) ? 10'(y_sum - YM) : y_sum[9:0];
            else if (cur_act[0] && !cur_act[1])
                mov_y = (cur_y < 10'(cur_step)) ? 10'({1'b0, cur_y} + YM - 11'(cur_step))
                                                : cur_y - 10'(cur_step);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= 8'd0;
            pending       <= 1'b0;
            sweep_overrun <= 1'b0;
        end else begin
            state         <= state_nxt;
            sweep_overrun <= 1'b0;
            if (state == SWEEP) begin
                idx <= (idx == LAST_IDX) ? 8'd0 : idx + 8'd1;
                if (frame_tick) begin
                    if (pending) sweep_overrun <= 1'b1;
                    else         pending       <= 1'b1;
                end
            end else begin
                idx <= 8'd0;
                // The pending tick is consumed here; a fresh tick on top of it is dropped.
                if (pending) begin
                    pending <= 1'b0;
                    if (frame_tick) sweep_overrun <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                spr_x[i]    <= 10'd0;
                spr_y[i]    <= 10'd0;
                spr_step[i] <= 4'd0;
                spr_act[i]  <= 4'd0;
                spr_img[i]  <= 8'd0;
            end
        end else if (state == SWEEP) begin
            spr_x[idx] <= mov_x;
            spr_y[idx] <= mov_y;
        end else if (wr_en) begin
            case (sprite_op)
                OP_ACT: spr_act[sprite_addr] <= sprite_action;
                OP_LD: begin
                    if (sprite_action[0]) spr_y[sprite_addr] <= ld_val;
                    else                  spr_x[sprite_addr] <= ld_val;
                end
                OP_MAP:  spr_img[sprite_addr]  <= data[7:0];
                OP_TM:   spr_step[sprite_addr] <= data[3:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= 32'd0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_word;
        end
    end

endmodule

// File: tb/tb_sprite_cmd_unit.sv
// Bench for sprite_cmd_unit: vector table, directed sweep/stall/reset sequences,
// and randomized commands with ticks checked against a behavioural sprite model.
module tb_sprite_cmd_unit;

    localparam int NUM_SPR = 256;
    localparam int X_MAX   = 640;
    localparam int Y_MAX   = 480;
    localparam logic [4:0] OP_ACT = 5'h10, OP_LD = 5'h11, OP_RD = 5'h12,
                           OP_MAP = 5'h13, OP_CORD = 5'h14, OP_TM = 5'h15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sprite_re = 1'b0, sprite_we = 1'b0;
    logic [4:0]  sprite_op = '0;
    logic [7:0]  sprite_addr = '0;
    logic [3:0]  sprite_action = '0;
    logic        sprite_use_imm = 1'b0;
    logic [9:0]  sprite_imm = '0;
    logic [31:0] reg_data = '0;
    logic        frame_tick = 1'b0;
    logic        cmd_stall, rd_valid, sweep_busy, sweep_overrun;
    logic [31:0] rd_data;

    sprite_cmd_unit dut (
        .clk(clk), .rst_n(rst_n), .sprite_re(sprite_re), .sprite_we(sprite_we),
        .sprite_op(sprite_op), .sprite_addr(sprite_addr), .sprite_action(sprite_action),
        .sprite_use_imm(sprite_use_imm), .sprite_imm(sprite_imm), .reg_data(reg_data),
        .frame_tick(frame_tick), .cmd_stall(cmd_stall), .rd_data(rd_data),
        .rd_valid(rd_valid), .sweep_busy(sweep_busy), .sweep_overrun(sweep_overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [4:0]  op;
        logic        re, we;
        logic [7:0]  addr;
        logic [3:0]  action;
        logic        use_imm;
        logic [9:0]  imm;
        logic [31:0] regd;
        logic        exp_valid;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vecs[$];

    int m_x[NUM_SPR], m_y[NUM_SPR], m_step[NUM_SPR], m_act[NUM_SPR], m_img[NUM_SPR];
    logic [31:0] m_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [4:0] op, logic re, logic we, logic [7:0] addr,
                                logic [3:0] action, logic use_imm, logic [9:0] imm,
                                logic [31:0] regd, logic ev, logic [31:0] ed);
        vec_t v;
        v.op = op; v.re = re; v.we = we; v.addr = addr; v.action = action;
        v.use_imm = use_imm; v.imm = imm; v.regd = regd; v.exp_valid = ev; v.exp_data = ed;
        return v;
    endfunction

    task automatic drive(input logic [4:0] op, input logic re, input logic we,
                         input logic [7:0] addr, input logic [3:0] action,
                         input logic use_imm, input logic [9:0] imm,
                         input logic [31:0] regd, input logic tick);
        sprite_op = op; sprite_re = re; sprite_we = we; sprite_addr = addr;
        sprite_action = action; sprite_use_imm = use_imm; sprite_imm = imm;
        reg_data = regd; frame_tick = tick;
        @(posedge clk); #1;
        sprite_re = 1'b0; sprite_we = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [4:0] op, input logic [7:0] addr,
                            input logic [31:0] exp);
        drive(op, 1'b1, 1'b0, addr, 4'd0, 1'b0, 10'd0, 32'd0, 1'b0);
        chk({name, "_valid"}, 32'(rd_valid), 32'd1);
        chk(name, rd_data, exp);
    endtask

    task automatic wait_sweep(input string name);
        int n = 0;
        while (sweep_busy && n < 400) begin
            n++;
            @(posedge clk); #1;
        end
        chk(name, n, 256);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_outputs", {rd_data[15:0], 11'd0, cmd_stall, rd_valid, sweep_busy,
                            sweep_overrun, 1'b0}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NUM_SPR; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_step[i] = 0; m_act[i] = 0; m_img[i] = 0;
        end
        m_rd = 32'd0;
    endtask

    function automatic void model_cmd(input logic [4:0] op, input bit re, input bit we,
                                      input int a, input logic [3:0] action,
                                      input bit use_imm, input logic [9:0] imm,
                                      input logic [31:0] regd, output bit valid);
        int d;
        valid = 1'b0;
        d = use_imm ? int'(imm) : int'(regd % 1024);
        if (re && !we && (op == OP_RD || op == OP_CORD)) begin
            valid = 1'b1;
            if (a >= NUM_SPR)     m_rd = 32'd0;
            else if (op == OP_RD) m_rd = 32'(m_act[a] * (1 << 24) + m_step[a] * (1 << 20) + m_img[a] * (1 << 12));
            else                  m_rd = 32'(m_y[a] * 65536 + m_x[a]);
        end else if (we && !re && a < NUM_SPR) begin
            if (op == OP_ACT) m_act[a] = int'(action);
            else if (op == OP_LD) begin
                if (action[0]) m_y[a] = (d >= Y_MAX) ? d - Y_MAX : d;
                else           m_x[a] = (d >= X_MAX) ? d - X_MAX : d;
            end
            else if (op == OP_MAP) m_img[a] = d % 256;
            else if (op == OP_TM)  m_step[a] = d % 16;
        end
    endfunction

    function automatic void model_sweep();
        for (int s = 0; s < NUM_SPR; s++) begin
            int st = m_step[s];
            bit up = m_act[s][0], dn = m_act[s][1], lf = m_act[s][2], rt = m_act[s][3];
            if (st != 0) begin
                if (rt && !lf)      m_x[s] = (m_x[s] + st >= X_MAX) ? m_x[s] + st - X_MAX : m_x[s] + st;
                else if (lf && !rt) m_x[s] = (m_x[s] < st) ? m_x[s] + X_MAX - st : m_x[s] - st;
                if (dn && !up)      m_y[s] = (m_y[s] + st >= Y_MAX) ? m_y[s] + st - Y_MAX : m_y[s] + st;
                else if (up && !dn) m_y[s] = (m_y[s] < st) ? m_y[s] + Y_MAX - st : m_y[s] - st;
            end
        end
    endfunction

    logic [4:0] r_op;
    logic       r_re, r_we, r_tick;
    bit         exp_v;
    int         sel, n, ovr;

    initial begin
        vecs.push_back(mk(OP_CORD, 1, 0, 8'd5, 4'h0, 1, 10'd0,   32'd0,         1, 32'h0000_0000));
        vecs.push_back(mk(OP_LD,   0, 1, 8'd1, 4'h0, 1, 10'd100, 32'd0,         0, 32'h0));
        vecs.push_back(mk(OP_LD,   0, 1, 8'd1, 4'h1, 0, 10'd7,   32'hABCD_E1DF, 0, 32'h0));
        vecs.push_back(mk(OP_TM,   0, 1, 8'd1, 4'h0, 1, 10'd3,   32'd0,         0, 32'h0));
        vecs.push_back(mk(OP_ACT,  0, 1, 8'd1, 4'hA, 1, 10'd0,   32'd0,         0, 32'h0));
        vecs.push_back(mk(OP_CORD, 1, 0, 8'd1, 4'h0, 1, 10'd0,   32'd0,         1, 32'h01DF_0064));
        vecs.push_back(mk(OP_RD,   1, 0, 8'd1, 4'h0, 1, 10'd0,   32'd0,         1, 32'h0A30_0000));
        vecs.push_back(mk(OP_MAP,  0, 1, 8'd2, 4'h0, 1, 10'h13C, 32'd0,         0, 32'h0));
        vecs.push_back(mk(OP_RD,   1, 0, 8'd2, 4'h0, 1, 10'd0,   32'd0,         1, 32'h0003_C000));
        vecs.push_back(mk(OP_LD,   0, 1, 8'd3, 4'h0, 1, 10'd700, 32'd0,         0, 32'h0));
        vecs.push_back(mk(OP_CORD, 1, 0, 8'd3, 4'h0, 1, 10'd0,   32'd0,         1, 32'h0000_003C));
        vecs.push_back(mk(OP_LD,   1, 1, 8'd3, 4'h0, 1, 10'd5,   32'd0,         0, 32'h0));
        vecs.push_back(mk(OP_LD,   1, 0, 8'd3, 4'h0, 1, 10'd5,   32'd0,         0, 32'h0));
        vecs.push_back(mk(OP_RD,   0, 1, 8'd3, 4'h0, 1, 10'd5,   32'd0,         0, 32'h0));
        vecs.push_back(mk(OP_CORD, 1, 0, 8'd3, 4'h0, 1, 10'd0,   32'd0,         1, 32'h0000_003C));
        vecs.push_back(mk(OP_LD,   0, 1, 8'd4, 4'h1, 1, 10'd1000, 32'd0,        0, 32'h0));
        vecs.push_back(mk(OP_CORD, 1, 0, 8'd4, 4'h0, 1, 10'd0,   32'd0,         1, 32'h0208_0000));

        do_reset();

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].action,
                  vecs[i].use_imm, vecs[i].imm, vecs[i].regd, 1'b0);
            chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) chk($sformatf("vec%0d_data", i), rd_data, vecs[i].exp_data);
        end

        // Sprite 1 moves right/down by 3: x 100->103, y 479 wraps to 2.
        drive(5'd0, 0, 0, 8'd0, 4'h0, 0, 10'd0, 32'd0, 1'b1);
        wait_sweep("sweep_len_a");
        read_chk("move_wrap_y", OP_CORD, 8'd1, 32'h0002_0067);

        // Sprite 6 moves left by 5 from x=2 -> 637; then up+down cancels.
        drive(OP_LD,  0, 1, 8'd6, 4'h0, 1, 10'd2, 32'd0, 1'b0);
        drive(OP_TM,  0, 1, 8'd6, 4'h0, 1, 10'd5, 32'd0, 1'b0);
        drive(OP_ACT, 0, 1, 8'd6, 4'h4, 1, 10'd0, 32'd0, 1'b0);
        drive(5'd0, 0, 0, 8'd0, 4'h0, 0, 10'd0, 32'd0, 1'b1);
        wait_sweep("sweep_len_b");
        read_chk("move_wrap_x", OP_CORD, 8'd6, 32'h0000_027D);
        drive(OP_LD,  0, 1, 8'd6, 4'h1, 1, 10'd10, 32'd0, 1'b0);
        drive(OP_ACT, 0, 1, 8'd6, 4'h3, 1, 10'd0,  32'd0, 1'b1);
        wait_sweep("sweep_len_c");
        read_chk("updown_cancel", OP_CORD, 8'd6, 32'h000A_027D);

        // Write held under stall, extra ticks during the sweep.
        drive(5'd0, 0, 0, 8'd0, 4'h0, 0, 10'd0, 32'd0, 1'b1);
        sprite_op = OP_MAP; sprite_we = 1'b1; sprite_addr = 8'd7;
        sprite_use_imm = 1'b1; sprite_imm = 10'h055;
        n = 0; ovr = 0;
        while (cmd_stall && n < 400) begin
            n++;
            frame_tick = (n == 10 || n == 20);
            @(posedge clk); #1;
            frame_tick = 1'b0;
            if (sweep_overrun) ovr++;
        end
        chk("stall_len", n, 256);
        @(posedge clk); #1;
        sprite_we = 1'b0;
        if (sweep_overrun) ovr++;
        chk("overrun_count", ovr, 1);
        chk("pending_sweep_busy", 32'(sweep_busy), 32'd1);
        wait_sweep("sweep_len_pend");
        read_chk("stalled_write", OP_RD, 8'd7, 32'h0005_5000);

        // Randomized commands against the behavioural model.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            sel    = $urandom_range(0, 7);
            r_tick = ($urandom_range(0, 39) == 0);
            case (sel)
                0: begin r_op = OP_ACT;  r_re = 0; r_we = 1; end
                1: begin r_op = OP_LD;   r_re = 0; r_we = 1; end
                2: begin r_op = OP_MAP;  r_re = 0; r_we = 1; end
                3: begin r_op = OP_TM;   r_re = 0; r_we = 1; end
                4: begin r_op = OP_RD;   r_re = 1; r_we = 0; end
                5: begin r_op = OP_CORD; r_re = 1; r_we = 0; end
                6: begin r_op = 5'(OP_ACT + 5'($urandom_range(0, 5))); r_re = 1; r_we = 1; end
                default: begin
                    r_op = 5'(OP_ACT + 5'($urandom_range(0, 5)));
                    r_re = (r_op == OP_ACT || r_op == OP_LD || r_op == OP_MAP || r_op == OP_TM);
                    r_we = !r_re;
                end
            endcase
            sprite_addr    = 8'($urandom_range(0, 7));
            sprite_action  = 4'($urandom);
            sprite_use_imm = 1'($urandom);
            sprite_imm     = 10'($urandom);
            reg_data       = $urandom;
            model_cmd(r_op, r_re, r_we, int'(sprite_addr), sprite_action, sprite_use_imm,
                      sprite_imm, reg_data, exp_v);
            drive(r_op, r_re, r_we, sprite_addr, sprite_action, sprite_use_imm,
                  sprite_imm, reg_data, r_tick);
            chk($sformatf("rnd%0d_valid", i), 32'(rd_valid), 32'(exp_v));
            chk($sformatf("rnd%0d_data", i), rd_data, m_rd);
            if (r_tick) begin
                model_sweep();
                wait_sweep($sformatf("rnd%0d_sweep", i));
            end
        end
        for (int s = 0; s < 8; s++) begin
            model_cmd(OP_CORD, 1, 0, s, 4'h0, 1'b0, 10'd0, 32'd0, exp_v);
            read_chk($sformatf("final_cord%0d", s), OP_CORD, 8'(s), m_rd);
        end

        // Reset in the middle of a sweep.
        drive(5'd0, 0, 0, 8'd0, 4'h0, 0, 10'd0, 32'd0, 1'b1);
        repeat (100) @(posedge clk);
        #1;
        chk("mid_sweep_busy", 32'(sweep_busy), 32'd1);
        do_reset();
        chk("post_rst_idle", 32'(sweep_busy), 32'd0);
        read_chk("post_rst_cord", OP_CORD, 8'd1, 32'd0);
        read_chk("post_rst_rd", OP_RD, 8'd7, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
